// File: rtl/fib_pkg.sv
// rtl/fib_pkg.sv - shared types and constants for the Fibonacci fill sequencer
package fib_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_INIT0 = 3'd1,
        S_INIT1 = 3'd2,
        S_READ  = 3'd3,
        S_WRITE = 3'd4,
        S_DONE  = 3'd5
    } fib_state_t;

    localparam int FIB_MIN_N = 2;

endpackage

// File: rtl/fib_seq_ctrl.sv
// rtl/fib_seq_ctrl.sv - drives regfile and adder to fill r[0..n-1] with a Fibonacci-style series
module fib_seq_ctrl
    import fib_pkg::*;
#(
    parameter int AW = 5,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [DW-1:0] f0,
    input  logic [DW-1:0] f1,
    input  logic [AW:0]   n,
    output logic [AW-1:0] ra0,
    output logic [AW-1:0] ra1,
    input  logic [DW-1:0] rd0,
    input  logic [DW-1:0] rd1,
    output logic          we,
    output logic [AW-1:0] wa,
    output logic [DW-1:0] wd,
    output logic [DW-1:0] alu_a,
    output logic [DW-1:0] alu_b,
    input  logic [DW-1:0] alu_y,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] last
);

    localparam logic [AW:0] N_MIN = (AW+1)'(FIB_MIN_N);
    localparam logic [AW:0] N_MAX = {1'b1, {AW{1'b0}}};

    fib_state_t    state_q, state_d;
    logic [AW:0]   k_q, k_d;
    logic [AW:0]   n_q, n_d;
    logic [DW-1:0] f0_q, f0_d, f1_q, f1_d;
    logic [DW-1:0] opa_q, opa_d, opb_q, opb_d;
    logic [DW-1:0] last_q, last_d;
    logic [AW:0]   n_clamped;

    always_comb begin
        n_clamped = n;
        if (n < N_MIN) begin
            n_clamped = N_MIN;
        end else if (n > N_MAX) begin
            n_clamped = N_MAX;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            k_q     <= '0;
            n_q     <= '0;
            f0_q    <= '0;
            f1_q    <= '0;
            opa_q   <= '0;
            opb_q   <= '0;
            last_q  <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            n_q     <= n_d;
            f0_q    <= f0_d;
            f1_q    <= f1_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            last_q  <= last_d;
        end
    end

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        n_d     = n_q;
        f0_d    = f0_q;
        f1_d    = f1_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        last_d  = last_q;
        ra0     = '0;
        ra1     = '0;
        we      = 1'b0;
        wa      = '0;
        wd      = '0;
        alu_a   = '0;
        alu_b   = '0;
        busy    = 1'b0;
        done    = 1'b0;
        last    = last_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    f0_d    = f0;
                    f1_d    = f1;
                    n_d     = n_clamped;
                    state_d = S_INIT0;
                end
            end
            S_INIT0: begin
                busy    = 1'b1;
                we      = 1'b1;
                wa      = '0;
                wd      = f0_q;
                last_d  = f0_q;
                state_d = S_INIT1;
            end
            S_INIT1: begin
                busy    = 1'b1;
                we      = 1'b1;
                wa      = AW'(1);
                wd      = f1_q;
                last_d  = f1_q;
                k_d     = (AW+1)'(2);
                state_d = (n_q == N_MIN) ? S_DONE : S_READ;
            end
            S_READ: begin
                // k stays below 2^AW here, so the AW-bit subtraction cannot wrap
                busy    = 1'b1;
                ra0     = k_q[AW-1:0] - AW'(2);
                ra1     = k_q[AW-1:0] - AW'(1);
                opa_d   = rd0;
                opb_d   = rd1;
                state_d = S_WRITE;
            end
            S_WRITE: begin
                busy   = 1'b1;
                alu_a  = opa_q;
                alu_b  = opb_q;
                we     = 1'b1;
                wa     = k_q[AW-1:0];
                wd     = alu_y;
                last_d = alu_y;
                if (k_q == n_q - (AW+1)'(1)) begin
                    state_d = S_DONE;
                end else begin
                    k_d     = k_q + (AW+1)'(1);
                    state_d = S_READ;
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Outputs are forced quiet while reset is asserted so an aborted run writes nothing more
        if (!rst_n) begin
            ra0   = '0;
            ra1   = '0;
            we    = 1'b0;
            wa    = '0;
            wd    = '0;
            alu_a = '0;
            alu_b = '0;
            busy  = 1'b0;
            done  = 1'b0;
            last  = '0;
        end
    end

endmodule

// File: tb/tb_fib_seq_ctrl.sv
// tb/tb_fib_seq_ctrl.sv - self-checking bench for fib_seq_ctrl with behavioural regfile and adder
module tb_fib_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [31:0] f0, f1;
    logic [5:0]  n;
    logic [4:0]  ra0, ra1, wa;
    logic [31:0] rd0, rd1, wd, alu_a, alu_b, alu_y, last;
    logic        we, busy, done;

    logic [31:0] mem [32];

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [31:0] f0;
        logic [31:0] f1;
        logic [5:0]  n;
        int          nq;
        logic [31:0] exp_last;
        int          exp_done;
    } vec_t;

    vec_t vt [8];

    fib_seq_ctrl #(.AW(5), .DW(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .f0    (f0),
        .f1    (f1),
        .n     (n),
        .ra0   (ra0),
        .ra1   (ra1),
        .rd0   (rd0),
        .rd1   (rd1),
        .we    (we),
        .wa    (wa),
        .wd    (wd),
        .alu_a (alu_a),
        .alu_b (alu_b),
        .alu_y (alu_y),
        .busy  (busy),
        .done  (done),
        .last  (last)
    );

    always #5 clk = ~clk;

    assign rd0   = mem[ra0];
    assign rd1   = mem[ra1];
    assign alu_y = alu_a + alu_b;

    always @(posedge clk) begin
        if (we) mem[wa] <= wd;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run(input logic [31:0] a, input logic [31:0] b, input logic [5:0] nn,
                       input int nq, input logic [31:0] exp_last, input int exp_done,
                       input logic [127:0] smask);
        logic [31:0] em [32];
        int nw, busy_n, done_at, expc;
        em[0] = a;
        em[1] = b;
        for (int k = 2; k < 32; k++) em[k] = em[k-2] + em[k-1];
        nw = 0; busy_n = 0; done_at = -1;
        @(negedge clk);
        f0 = a; f1 = b; n = nn; start = 1'b1;
        @(negedge clk);
        // changes after the start edge must not affect the run
        f0 = ~a; f1 = ~b; n = 6'd5;
        for (int c = 1; c <= 200; c++) begin
            if (c > 1) @(negedge clk);
            if (busy) busy_n++;
            if (we) begin
                if (nw >= nq) begin
                    check("extra_write", 64'(wa), 64'hFF);
                end else begin
                    expc = (nw < 2) ? nw + 1 : 2 * nw;
                    check("wr_addr", 64'(wa), 64'(nw));
                    check("wr_data", 64'(wd), 64'(em[nw]));
                    check("wr_cycle", 64'(c), 64'(expc));
                end
                nw++;
            end
            start = smask[c];
            if (done) begin
                done_at = c;
                break;
            end
        end
        check("done_cycle", 64'(done_at), 64'(exp_done));
        check("write_count", 64'(nw), 64'(nq));
        check("busy_cycles", 64'(busy_n), 64'(exp_done - 1));
        check("last", 64'(last), 64'(exp_last));
        @(negedge clk);
        check("done_one_cycle", 64'(done), 64'd0);
        check("idle_after_done", 64'(busy), 64'd0);
        start = 1'b0;
        for (int i = 0; i < nq; i++) check("regfile", 64'(mem[i]), 64'(em[i]));
    endtask

    initial begin
        vt[0] = '{32'd1,         32'd1, 6'd8,  8,  32'd21,      15};
        vt[1] = '{32'd7,         32'd9, 6'd0,  2,  32'd9,       3};
        vt[2] = '{32'd7,         32'd9, 6'd1,  2,  32'd9,       3};
        vt[3] = '{32'hFFFFFFFF,  32'd1, 6'd4,  4,  32'd1,       7};
        vt[4] = '{32'd0,         32'd1, 6'd63, 32, 32'd1346269, 63};
        vt[5] = '{32'd3,         32'd5, 6'd3,  3,  32'd8,       5};
        vt[6] = '{32'd4,         32'd6, 6'd2,  2,  32'd6,       3};
        vt[7] = '{32'd0,         32'd1, 6'd33, 32, 32'd1346269, 63};

        rst_n = 1'b0; start = 1'b0; f0 = '0; f1 = '0; n = '0;
        repeat (2) @(negedge clk);
        check("rst_we", 64'(we), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_last", 64'(last), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_outputs", {ra0, ra1, wa, wd}, 64'd0);
        check("post_rst_alu", {alu_a, alu_b}, 64'd0);
        check("post_rst_busy", 64'(busy), 64'd0);

        for (int i = 0; i < 8; i++) begin
            run(vt[i].f0, vt[i].f1, vt[i].n, vt[i].nq, vt[i].exp_last, vt[i].exp_done, 128'd0);
            if (vt[i].nq == 4) begin
                check("ovf_r2", 64'(mem[2]), 64'd0);
                check("ovf_r3", 64'(mem[3]), 64'd1);
            end
        end

        // start pulses in cycles 3, 5 and the DONE cycle 11 are all ignored
        run(32'd2, 32'd1, 6'd6, 6, 32'd11, 11, (128'd1 << 3) | (128'd1 << 5) | (128'd1 << 11));
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("no_restart_busy", 64'(busy), 64'd0);
            check("no_restart_done", 64'(done), 64'd0);
        end

        // reset asserted for one edge during the WRITE of k=4
        @(negedge clk);
        f0 = 32'd2; f1 = 32'd3; n = 6'd8; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        check("pre_rst_we", 64'(we), 64'd1);
        check("pre_rst_wa", 64'(wa), 64'd4);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("abort_we", 64'(we), 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        check("abort_last", 64'(last), 64'd0);
        @(negedge clk);
        check("abort_stays_idle", 64'(busy), 64'd0);
        check("abort_r0", 64'(mem[0]), 64'd2);
        check("abort_r1", 64'(mem[1]), 64'd3);
        check("abort_r2", 64'(mem[2]), 64'd5);
        check("abort_r3", 64'(mem[3]), 64'd8);

        run(32'd1, 32'd2, 6'd5, 5, 32'd8, 9, 128'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
